// File: rtl/startup_pkg.sv
// Shared encodings and sizing helpers for the startup sequencer.
package startup_pkg;

    typedef enum logic [2:0] {
        ST_HOLD_GSR   = 3'd0,
        ST_HOLD_GTS   = 3'd1,
        ST_WAIT_EOS   = 3'd2,
        ST_CHECK_MCLK = 3'd3,
        ST_READY      = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_EOS_TIMEOUT = 2'd1,
        ERR_MCLK_DEAD   = 2'd2,
        ERR_EOS_LOST    = 2'd3
    } err_t;

    // Cycle counter width: enough to hold (largest interval - 1).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous inputs, synchronous reset to 0.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/startup_seq.sv
// Startup sequencer: sequences GSR/GTS, then qualifies EOS and CFGMCLK activity
// before releasing the datapath reset.
module startup_seq
    import startup_pkg::*;
#(
    parameter int unsigned GSR_CYCLES     = 16,
    parameter int unsigned GTS_CYCLES     = 8,
    parameter int unsigned EOS_TIMEOUT    = 1024,
    parameter int unsigned MCLK_WINDOW    = 256,
    parameter int unsigned MCLK_MIN_EDGES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic       eos_in,
    input  logic       cfgmclk_in,
    output logic       gsr_out,
    output logic       gts_out,
    output logic       user_rst,
    output logic       ready,
    output logic [1:0] err,
    output logic [2:0] state_out
);

    localparam int unsigned CW = cnt_width(GSR_CYCLES, GTS_CYCLES, EOS_TIMEOUT, MCLK_WINDOW);
    localparam int unsigned EW = $clog2(MCLK_MIN_EDGES + 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [EW-1:0]   edges, edges_next, edges_inc;
    logic            gsr_next, gts_next, user_rst_next, ready_next;
    logic [1:0]      err_next;
    logic            eos_s, mclk_s, mclk_h, mclk_rise;

    sync_2ff u_sync_eos (
        .clock (clock),
        .reset (reset),
        .d     (eos_in),
        .q     (eos_s)
    );

    sync_2ff u_sync_mclk (
        .clock (clock),
        .reset (reset),
        .d     (cfgmclk_in),
        .q     (mclk_s)
    );

    assign mclk_rise = mclk_s & ~mclk_h;
    assign state_out = state;

    // Edge count including a rise seen this cycle, saturating at the threshold.
    always_comb begin
        edges_inc = edges;
        if (mclk_rise && (edges != EW'(MCLK_MIN_EDGES))) begin
            edges_inc = edges + EW'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CW'(1);
        edges_next    = edges;
        gsr_next      = gsr_out;
        gts_next      = gts_out;
        user_rst_next = user_rst;
        ready_next    = ready;
        err_next      = err;

        case (state)
            ST_HOLD_GSR: begin
                if (cnt == CW'(GSR_CYCLES - 1)) begin
                    state_next = ST_HOLD_GTS;
                    gsr_next   = 1'b0;
                end
            end
            ST_HOLD_GTS: begin
                if (cnt == CW'(GTS_CYCLES - 1)) begin
                    state_next = ST_WAIT_EOS;
                    gts_next   = 1'b0;
                end
            end
            ST_WAIT_EOS: begin
                if (eos_s) begin
                    state_next = ST_CHECK_MCLK;
                end else if (cnt == CW'(EOS_TIMEOUT - 1)) begin
                    state_next = ST_FAULT;
                    err_next   = ERR_EOS_TIMEOUT;
                end
            end
            ST_CHECK_MCLK: begin
                edges_next = edges_inc;
                if (cnt == CW'(MCLK_WINDOW - 1)) begin
                    if (edges_inc >= EW'(MCLK_MIN_EDGES)) begin
                        state_next    = ST_READY;
                        user_rst_next = 1'b0;
                        ready_next    = 1'b1;
                    end else begin
                        state_next = ST_FAULT;
                        err_next   = ERR_MCLK_DEAD;
                    end
                end
            end
            ST_READY: begin
                if (!eos_s) begin
                    state_next = ST_FAULT;
                    err_next   = ERR_EOS_LOST;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase

        if (state_next == ST_FAULT) begin
            user_rst_next = 1'b1;
            ready_next    = 1'b0;
            gts_next      = 1'b1;
            gsr_next      = 1'b0;
        end

        if (state_next != state) begin
            cnt_next   = '0;
            edges_next = '0;
        end

        // Restart only from terminal states; behaves like a reset of the sequence.
        if (restart && ((state == ST_READY) || (state == ST_FAULT))) begin
            state_next    = ST_HOLD_GSR;
            cnt_next      = '0;
            edges_next    = '0;
            gsr_next      = 1'b1;
            gts_next      = 1'b1;
            user_rst_next = 1'b1;
            ready_next    = 1'b0;
            err_next      = ERR_NONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_HOLD_GSR;
            cnt      <= '0;
            edges    <= '0;
            mclk_h   <= 1'b0;
            gsr_out  <= 1'b1;
            gts_out  <= 1'b1;
            user_rst <= 1'b1;
            ready    <= 1'b0;
            err      <= ERR_NONE;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            edges    <= edges_next;
            mclk_h   <= mclk_s;
            gsr_out  <= gsr_next;
            gts_out  <= gts_next;
            user_rst <= user_rst_next;
            ready    <= ready_next;
            err      <= err_next;
        end
    end

endmodule
